// File: rtl/alarm_pkg.sv
// alarm_pkg: state encoding and tick-count width shared by the alarm sequencer files
package alarm_pkg;
  localparam int CNT_W = 8;
  typedef enum logic [2:0] {
    DISARMED = 3'd0,
    EXIT     = 3'd1,
    ARMED    = 3'd2,
    ENTRY    = 3'd3,
    ALARM    = 3'd4,
    SILENCED = 3'd5
  } state_t;
endpackage

// File: rtl/alarm_sequencer_if.sv
// alarm_sequencer_if: groups the sequencer's control/status signals
//   master: drives tick/arm/disarm/doorSensor/zoneSensor, observes the outputs
//   slave : the sequencer, drives timerEN/state/remaining/buzzer/siren
interface alarm_sequencer_if;
  import alarm_pkg::*;
  logic             tick;
  logic             arm;
  logic             disarm;
  logic             doorSensor;
  logic             zoneSensor;
  logic             timerEN;
  logic [2:0]       state;
  logic [CNT_W-1:0] remaining;
  logic             buzzer;
  logic             siren;
  modport master (
    output tick, arm, disarm, doorSensor, zoneSensor,
    input  timerEN, state, remaining, buzzer, siren
  );
  modport slave (
    input  tick, arm, disarm, doorSensor, zoneSensor,
    output timerEN, state, remaining, buzzer, siren
  );
endinterface

// File: rtl/tick_countdown.sv
// tick_countdown: loadable down-counter holding the ticks left in the current phase
//   clkSignal/RST: clock, async active-low reset
//   load/loadValue: overwrite the count; dec: count down, saturating at 1
//   remaining: current count; isOne: count equals 1
module tick_countdown
  import alarm_pkg::*;
(
  input  logic             clkSignal,
  input  logic             RST,
  input  logic             load,
  input  logic [CNT_W-1:0] loadValue,
  input  logic             dec,
  output logic [CNT_W-1:0] remaining,
  output logic             isOne
);
  always_ff @(posedge clkSignal or negedge RST)
    if (!RST) remaining <= '0;
    else if (load) remaining <= loadValue;
    else if (dec && remaining > CNT_W'(1)) remaining <= remaining - CNT_W'(1);
  assign isOne = remaining == CNT_W'(1);
endmodule

// File: rtl/alarm_sequencer.sv
// alarm_sequencer: tick-timed exit/entry/siren supervisory FSM
//   clkSignal/RST: clock, async active-low reset
//   bus (slave): tick/arm/disarm/doorSensor/zoneSensor in;
//                timerEN/state/remaining/buzzer/siren out, all registered
module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter int EXIT_TICKS  = 30,
  parameter int ENTRY_TICKS = 20,
  parameter int SIREN_TICKS = 180
) (
  input logic         clkSignal,
  input logic         RST,
  alarm_sequencer_if.slave bus
);
  state_t           st, nxt;
  logic             en, bz, sr, load, dec, is_one, vt;
  logic [CNT_W-1:0] load_value, rem;
  // ticks only count while the upstream timer is actually enabled
  assign vt = bus.tick & en;
  always_comb begin
    nxt        = st;
    load       = 1'b0;
    load_value = '0;
    dec        = 1'b0;
    if (bus.disarm) begin
      nxt  = DISARMED;
      load = 1'b1;
    end else begin
      case (st)
        DISARMED: if (bus.arm) begin
          nxt        = EXIT;
          load       = 1'b1;
          load_value = CNT_W'(EXIT_TICKS);
        end
        EXIT: if (vt) begin
          nxt  = is_one ? ARMED : EXIT;
          load = is_one;
          dec  = !is_one;
        end
        ARMED: if (bus.zoneSensor) begin
          nxt        = ALARM;
          load       = 1'b1;
          load_value = CNT_W'(SIREN_TICKS);
        end else if (bus.doorSensor) begin
          nxt        = ENTRY;
          load       = 1'b1;
          load_value = CNT_W'(ENTRY_TICKS);
        end
        ENTRY: if (bus.zoneSensor || (vt && is_one)) begin
          nxt        = ALARM;
          load       = 1'b1;
          load_value = CNT_W'(SIREN_TICKS);
        end else dec = vt;
        ALARM: if (vt) begin
          nxt  = is_one ? SILENCED : ALARM;
          load = is_one;
          dec  = !is_one;
        end
        SILENCED: if (bus.zoneSensor || bus.doorSensor) begin
          nxt        = ALARM;
          load       = 1'b1;
          load_value = CNT_W'(SIREN_TICKS);
        end
        default: begin
          nxt  = DISARMED;
          load = 1'b1;
        end
      endcase
    end
  end
  // timerEN stays low on the first cycle of every timed phase so the timer restarts
  always_ff @(posedge clkSignal or negedge RST)
    if (!RST) begin
      st <= DISARMED;
      en <= 1'b0;
      bz <= 1'b0;
      sr <= 1'b0;
    end else begin
      st <= nxt;
      en <= (nxt == EXIT || nxt == ENTRY || nxt == ALARM) && nxt == st;
      bz <= nxt == EXIT || nxt == ENTRY;
      sr <= nxt == ALARM;
    end
  tick_countdown u_cnt (
    .clkSignal(clkSignal),
    .RST(RST),
    .load(load),
    .loadValue(load_value),
    .dec(dec),
    .remaining(rem),
    .isOne(is_one)
  );
  assign bus.state     = st;
  assign bus.timerEN   = en;
  assign bus.buzzer    = bz;
  assign bus.siren     = sr;
  assign bus.remaining = rem;
endmodule

// File: tb/tb_alarm_sequencer.sv
// tb_alarm_sequencer: directed plus randomized checks of alarm_sequencer against a phase-level model
module tb_alarm_sequencer;
  localparam int EXIT_T  = 3;
  localparam int ENTRY_T = 20;
  localparam int SIREN_T = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   m_st, m_rem;
  bit   m_en;
  bit   timed_tab [0:5] = '{0, 1, 0, 1, 1, 0};
  bit   buzz_tab  [0:5] = '{0, 1, 0, 1, 0, 0};
  bit   sir_tab   [0:5] = '{0, 0, 0, 0, 1, 0};
  always #5 clk = ~clk;
  alarm_sequencer_if bus();
  alarm_sequencer #(.EXIT_TICKS(EXIT_T), .ENTRY_TICKS(ENTRY_T), .SIREN_TICKS(SIREN_T)) dut (
    .clkSignal(clk),
    .RST(rst_n),
    .bus(bus)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic m_reset();
    m_st  = 0;
    m_rem = 0;
    m_en  = 0;
  endtask
  // next phase and count from the behavioural rules; phases restart the timer on any change
  task automatic m_edge();
    bit vt;
    int ns, nr;
    vt = bus.tick && m_en;
    ns = m_st;
    nr = m_rem;
    if (bus.disarm) begin
      ns = 0;
      nr = 0;
    end else if (m_st == 0) begin
      if (bus.arm) begin ns = 1; nr = EXIT_T; end
    end else if (m_st == 2 || m_st == 5) begin
      if (bus.zoneSensor) begin ns = 4; nr = SIREN_T; end
      else if (bus.doorSensor) begin
        ns = (m_st == 2) ? 3 : 4;
        nr = (m_st == 2) ? ENTRY_T : SIREN_T;
      end
    end else if (m_st == 3 && bus.zoneSensor) begin
      ns = 4;
      nr = SIREN_T;
    end else if (vt) begin
      if (m_rem > 1) nr = m_rem - 1;
      else begin
        ns = (m_st == 1) ? 2 : (m_st == 3) ? 4 : 5;
        nr = (ns == 4) ? SIREN_T : 0;
      end
    end
    m_en  = timed_tab[ns] && ns == m_st;
    m_st  = ns;
    m_rem = nr;
  endtask
  task automatic check_all();
    chk("state", bus.state, m_st);
    chk("remaining", bus.remaining, m_rem);
    chk("timerEN", bus.timerEN, m_en);
    chk("buzzer", bus.buzzer, buzz_tab[m_st]);
    chk("siren", bus.siren, sir_tab[m_st]);
  endtask
  task automatic step();
    @(posedge clk);
    if (!rst_n) m_reset();
    else m_edge();
    #1 check_all();
  endtask
  task automatic ticks(input int n);
    bus.tick = 1'b1;
    repeat (n) step();
    bus.tick = 1'b0;
  endtask
  task automatic pulse_arm();
    bus.arm = 1'b1;
    step();
    bus.arm = 1'b0;
  endtask
  initial begin
    bus.tick = 0; bus.arm = 0; bus.disarm = 0; bus.doorSensor = 0; bus.zoneSensor = 0;
    m_reset();
    #12;
    check_all();
    rst_n = 1'b1;
    pulse_arm();
    chk("exit_en_low", bus.timerEN, 0);
    chk("exit_buzzer", bus.buzzer, 1);
    chk("exit_load", bus.remaining, EXIT_T);
    ticks(1);
    chk("exit_dropped_tick", bus.remaining, EXIT_T);
    chk("exit_en_high", bus.timerEN, 1);
    ticks(EXIT_T);
    chk("armed_state", bus.state, 2);
    chk("armed_buzzer", bus.buzzer, 0);
    chk("armed_en", bus.timerEN, 0);
    pulse_arm();
    chk("arm_ignored", bus.state, 2);
    bus.doorSensor = 1'b1;
    step();
    bus.doorSensor = 1'b0;
    chk("entry_load", bus.remaining, ENTRY_T);
    ticks(1);
    chk("entry_dropped_tick", bus.remaining, ENTRY_T);
    ticks(ENTRY_T - 5);
    chk("entry_five", bus.remaining, 5);
    bus.disarm = 1'b1;
    ticks(1);
    bus.disarm = 1'b0;
    chk("disarm_tick_state", bus.state, 0);
    chk("disarm_tick_rem", bus.remaining, 0);
    chk("disarm_tick_buzz", bus.buzzer, 0);
    pulse_arm();
    step();
    ticks(EXIT_T);
    bus.doorSensor = 1'b1;
    step();
    bus.doorSensor = 1'b0;
    step();
    ticks(ENTRY_T);
    chk("alarm_state", bus.state, 4);
    chk("alarm_siren", bus.siren, 1);
    chk("alarm_load", bus.remaining, SIREN_T);
    ticks(1);
    chk("alarm_dropped_tick", bus.remaining, SIREN_T);
    ticks(SIREN_T);
    chk("silenced_state", bus.state, 5);
    chk("silenced_siren", bus.siren, 0);
    bus.zoneSensor = 1'b1;
    step();
    bus.zoneSensor = 1'b0;
    chk("realarm_state", bus.state, 4);
    chk("realarm_rem", bus.remaining, SIREN_T);
    chk("realarm_siren", bus.siren, 1);
    step();
    ticks(1);
    chk("alarm_dec", bus.remaining, SIREN_T - 1);
    #2 rst_n = 1'b0;
    m_reset();
    #1 check_all();
    chk("async_siren", bus.siren, 0);
    bus.arm = 1'b1;
    step();
    bus.arm = 1'b0;
    #3 rst_n = 1'b1;
    repeat (800) begin
      bus.tick       = $urandom_range(99) < 45;
      bus.arm        = $urandom_range(99) < 10;
      bus.disarm     = $urandom_range(99) < 2;
      bus.doorSensor = $urandom_range(99) < 8;
      bus.zoneSensor = $urandom_range(99) < 3;
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
